// File: rtl/pc_trace_checker.sv
// Commit-trace checker: compares every PC change of the CPU against a preloaded
// expected trace and latches a pass/fail verdict with failing index and cause.
module pc_trace_checker #(
  parameter int unsigned PC_W           = 9,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned RIDX_W         = 3,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned HALT_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [PC_W-1:0]                       pc,
  input  logic                                  rf_we,
  input  logic [RIDX_W-1:0]                     rf_widx,
  input  logic [DATA_W-1:0]                     rf_wdata,
  input  logic                                  mem_we,
  input  logic [PC_W-1:0]                       mem_addr,
  input  logic [DATA_W-1:0]                     mem_wdata,
  input  logic                                  exp_we,
  input  logic [$clog2(DEPTH)-1:0]              exp_addr,
  input  logic [2+PC_W+RIDX_W+DATA_W-1:0]       exp_data,
  input  logic [$clog2(DEPTH):0]                n_entries,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  pass,
  output logic                                  fail,
  output logic [$clog2(DEPTH)-1:0]              fail_idx,
  output logic [2:0]                            fail_code,
  output logic [$clog2(DEPTH):0]                retired
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned EW   = 2 + PC_W + RIDX_W + DATA_W;
  localparam int unsigned NREG = 2 ** RIDX_W;
  localparam int unsigned MAXC = (TIMEOUT_CYCLES > HALT_CYCLES) ? TIMEOUT_CYCLES : HALT_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t            state, state_next;
  logic [EW-1:0]     trace_mem [DEPTH];
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] shadow [NREG];
  logic [NREG-1:0]   valid;
  logic              mw_flag;
  logic [PC_W-1:0]   mw_addr;
  logic [DATA_W-1:0] mw_data;
  logic [CW-1:0]     stall;
  logic [AW:0]       ptr, n_q;

  logic [EW-1:0]     entry;
  logic [1:0]        kind;
  logic [PC_W-1:0]   epc;
  logic [RIDX_W-1:0] eidx;
  logic [DATA_W-1:0] evalue;
  logic              reg_hit, reg_ok, mw_flag_b;
  logic [DATA_W-1:0] reg_val, mw_data_b;
  logic [PC_W-1:0]   mw_addr_b;
  logic              go, pc_change, accept;
  logic [2:0]        code;

  assign entry = trace_mem[ptr[AW-1:0]];
  assign {kind, epc, eidx, evalue} = entry;

  // Writes landing on the same edge as the PC change take part in its check.
  assign reg_hit   = rf_we && (rf_widx == eidx);
  assign reg_val   = reg_hit ? rf_wdata : shadow[eidx];
  assign reg_ok    = reg_hit || valid[eidx];
  assign mw_flag_b = mem_we || mw_flag;
  assign mw_addr_b = mem_we ? mem_addr : mw_addr;
  assign mw_data_b = mem_we ? mem_wdata : mw_data;

  assign go   = start && (state != RUN);
  assign busy = (state == RUN);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_change  = 1'b0;
    accept     = 1'b0;
    code       = '0;
    if (state == RUN) begin
      if (pc != pc_q) begin
        pc_change = 1'b1;
        if (ptr == n_q)                                          code = 3'd5;
        else if (pc != epc)                                      code = 3'd1;
        else if (kind == 2'd1 && (!reg_ok || reg_val != evalue)) code = 3'd2;
        else if (kind == 2'd2 && (!mw_flag_b || mw_addr_b != evalue[PC_W-1:0] ||
                                  mw_data_b != reg_val))         code = 3'd3;
        else                                                     accept = 1'b1;
        if (!accept) state_next = FAIL;
      end else if (ptr == n_q) begin
        if (stall >= CW'(HALT_CYCLES - 1)) state_next = PASS;
      end else if (stall >= CW'(TIMEOUT_CYCLES - 1)) begin
        code       = 3'd4;
        state_next = FAIL;
      end
    end else if (start) begin
      state_next = RUN;
    end
  end

  // Expected table has no reset; it survives reset and is frozen while running.
  always_ff @(posedge clk) begin
    if (exp_we && state != RUN) trace_mem[exp_addr] <= exp_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      valid     <= '0;
      mw_flag   <= 1'b0;
      mw_addr   <= '0;
      mw_data   <= '0;
      stall     <= '0;
      ptr       <= '0;
      n_q       <= '0;
      retired   <= '0;
      fail_idx  <= '0;
      fail_code <= '0;
      for (int unsigned i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      if (rf_we) shadow[rf_widx] <= rf_wdata;
      if (go) begin
        n_q       <= (n_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n_entries;
        ptr       <= '0;
        retired   <= '0;
        pc_q      <= pc;
        mw_flag   <= 1'b0;
        stall     <= '0;
        valid     <= '0;
        fail_idx  <= '0;
        fail_code <= '0;
      end else if (state == RUN) begin
        if (mem_we) begin
          mw_flag <= 1'b1;
          mw_addr <= mem_addr;
          mw_data <= mem_wdata;
        end
        if (pc_change) begin
          pc_q  <= pc;
          stall <= '0;
        end else if (stall != '1) begin
          stall <= stall + CW'(1);
        end
        if (accept) begin
          ptr     <= ptr + (AW+1)'(1);
          retired <= retired + (AW+1)'(1);
          mw_flag <= 1'b0;
        end
        if (state_next == FAIL) begin
          fail_idx  <= ptr[AW-1:0];
          fail_code <= code;
        end
      end
      // A write on the start cycle survives the valid-bit clear.
      if (rf_we) valid[rf_widx] <= 1'b1;
    end
  end
endmodule
